// File: rtl/mac_seq_fp_if.sv
// rtl/mac_seq_fp_if.sv - job, beat stream and result signals of the dot-product engine
//
// Purpose: bundles the job request (start/len/bias/ack), the beat stream
//          (in_valid/in_ready/a/b) and the result (y/sat/done) of mac_seq_fp.
// Ports (by modport):
//   master : drives start, len, bias, in_valid, a, b; observes ack, in_ready, y, sat, done
//   slave  : the engine side, the reverse directions
interface mac_seq_fp_if #(
  parameter int WIDTH  = 8,
  parameter int N      = 2,
  parameter int OWIDTH = 16,
  parameter int LENW   = 5
);
  logic                 start;
  logic [LENW-1:0]      len;
  logic [2*WIDTH-1:0]   bias;
  logic                 ack;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   a;
  logic [N*WIDTH-1:0]   b;
  logic [OWIDTH-1:0]    y;
  logic                 sat;
  logic                 done;

  modport master (
    output start, len, bias, in_valid, a, b,
    input  ack, in_ready, y, sat, done
  );

  modport slave (
    input  start, len, bias, in_valid, a, b,
    output ack, in_ready, y, sat, done
  );
endinterface

// File: rtl/mac_seq_fp.sv
// rtl/mac_seq_fp.sv - multi-beat fixed-point dot-product engine with saturating accumulator
//
// Purpose: per job, takes len beats of N signed lane pairs, accumulates the exact
//          lane-product sums onto a bias in a saturating ACCW-bit accumulator, then
//          rounds (half up) and saturates the total to OWIDTH bits with OFR fraction bits.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of mac_seq_fp_if:
//        start/len/bias in, ack out       job request, 1-cycle accept pulse
//        in_valid/a/b in, in_ready out    beat stream, lane i at [i*WIDTH +: WIDTH]
//        y/sat/done out                   result, clip flag, 1-cycle update pulse
module mac_seq_fp #(
  parameter int WIDTH  = 8,
  parameter int N      = 2,
  parameter int IFR    = 4,
  parameter int OFR    = 5,
  parameter int OWIDTH = 16,
  parameter int ACCW   = 32,
  parameter int MAXLEN = 16,
  parameter int LENW   = 5
) (
  input  logic        clk,
  input  logic        rst,
  mac_seq_fp_if.slave bus
);

  localparam int PW = 2 * WIDTH;            // one lane product
  localparam int SW = PW + $clog2(N);       // exact sum of N lane products
  localparam int S  = 2 * IFR - OFR;        // fraction bits dropped at the output

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [ACCW:0]   OMAX    = {{(ACCW-OWIDTH+2){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [ACCW:0]   OMIN    = ~OMAX;
  localparam logic signed [ACCW:0]   RND     =
    (S == 0) ? '0 : ({{ACCW{1'b0}}, 1'b1} << ((S == 0) ? 0 : S - 1));
  localparam logic [LENW-1:0]        LEN_MAX = LENW'(MAXLEN);

  logic [1:0]              state_q, state_d;
  logic [LENW-1:0]         len_q, len_d;
  logic [LENW-1:0]         cnt_q, cnt_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic signed [SW-1:0]    stage_q, stage_d;
  logic                    stage_vld_q, stage_vld_d;
  logic                    ack_q, ack_d;
  logic                    done_q, done_d;
  logic                    sat_q, sat_d;
  logic [OWIDTH-1:0]       y_q, y_d;

  // Exact-width sum of the N lane products of the current beat.
  logic signed [PW-1:0] lane_a, lane_b, lane_p;
  logic signed [SW-1:0] lane_sum;
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    lane_p   = '0;
    lane_sum = '0;
    for (int i = 0; i < N; i++) begin
      lane_a   = PW'($signed(bus.a[i*WIDTH +: WIDTH]));
      lane_b   = PW'($signed(bus.b[i*WIDTH +: WIDTH]));
      lane_p   = lane_a * lane_b;
      lane_sum = lane_sum + SW'(lane_p);
    end
  end

  // Saturating add of the staged beat sum; one extra bit exposes the overflow.
  logic signed [ACCW:0] acc_sum;
  logic                 acc_ovf;
  always_comb begin
    acc_sum = {acc_q[ACCW-1], acc_q} + {{(ACCW+1-SW){stage_q[SW-1]}}, stage_q};
    acc_ovf = acc_sum[ACCW] != acc_sum[ACCW-1];
  end

  // Round half up, arithmetic shift, then clamp into the output range.
  logic signed [ACCW:0] rnd_sum, rnd_res;
  logic                 clamp_hi, clamp_lo;
  always_comb begin
    rnd_sum  = {acc_q[ACCW-1], acc_q} + RND;
    rnd_res  = rnd_sum >>> S;
    clamp_hi = rnd_res > OMAX;
    clamp_lo = rnd_res < OMIN;
  end

  logic [LENW-1:0] len_in;
  logic [LENW-1:0] cnt_inc;
  always_comb begin
    len_in  = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    cnt_inc = cnt_q + LENW'(1);
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    stage_d     = stage_q;
    stage_vld_d = 1'b0;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    sat_d       = sat_q;
    y_d         = y_q;

    if (stage_vld_q) begin
      if (acc_ovf) begin
        acc_d = acc_sum[ACCW] ? ACC_MIN : ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACCW-1:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d   = len_in;
          cnt_d   = '0;
          acc_d   = {{(ACCW-PW){bus.bias[PW-1]}}, bus.bias};
          ovf_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = (len_in == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.in_valid) begin
          stage_d     = lane_sum;
          stage_vld_d = 1'b1;
          cnt_d       = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_FIN;
      end
      ST_FIN: begin
        if (clamp_hi)      y_d = OMAX[OWIDTH-1:0];
        else if (clamp_lo) y_d = OMIN[OWIDTH-1:0];
        else               y_d = rnd_res[OWIDTH-1:0];
        sat_d   = ovf_q | clamp_hi | clamp_lo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      y_q         <= y_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.sat      = sat_q;
  assign bus.y        = y_q;
  assign bus.in_ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_mac_seq_fp.sv
// tb/tb_mac_seq_fp.sv - self-checking bench for mac_seq_fp against an arithmetic model
module tb_mac_seq_fp;
  localparam int WIDTH  = 8;
  localparam int N      = 2;
  localparam int IFR    = 4;
  localparam int OFR    = 5;
  localparam int OWIDTH = 16;
  localparam int ACCW   = 32;
  localparam int MAXLEN = 16;
  localparam int LENW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq_fp_if #(.WIDTH(WIDTH), .N(N), .OWIDTH(OWIDTH), .LENW(LENW)) bus ();

  mac_seq_fp #(
    .WIDTH(WIDTH), .N(N), .IFR(IFR), .OFR(OFR), .OWIDTH(OWIDTH),
    .ACCW(ACCW), .MAXLEN(MAXLEN), .LENW(LENW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Handshake monitors; jobs compare before/after snapshots.
  int beat_cnt = 0;
  int ack_cnt  = 0;
  int rdy_cnt  = 0;
  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) beat_cnt++;
    if (bus.ack) ack_cnt++;
    if (bus.in_ready) rdy_cnt++;
  end

  int ta [MAXLEN][N];
  int tbv[MAXLEN][N];

  // Reference: Q8 accumulation saturating at 32 bits, round half up to Q5, clamp to 16 bits.
  task automatic model(input int len, input int bias, output int ey, output int esat);
    longint acc, r, s, amax, amin, omax, omin;
    int eff, sh, ovf;
    amax = (longint'(1) <<< (ACCW - 1)) - 1;
    amin = -(longint'(1) <<< (ACCW - 1));
    omax = (longint'(1) <<< (OWIDTH - 1)) - 1;
    omin = -(longint'(1) <<< (OWIDTH - 1));
    sh   = 2 * IFR - OFR;
    eff  = (len > MAXLEN) ? MAXLEN : len;
    acc  = bias;
    ovf  = 0;
    for (int j = 0; j < eff; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) s += longint'(ta[j][i]) * longint'(tbv[j][i]);
      acc += s;
      if (acc > amax) begin acc = amax; ovf = 1; end
      if (acc < amin) begin acc = amin; ovf = 1; end
    end
    r = (sh == 0) ? acc : ((acc + (longint'(1) <<< (sh - 1))) >>> sh);
    esat = ovf;
    if (r > omax) begin r = omax; esat = 1; end
    if (r < omin) begin r = omin; esat = 1; end
    ey = int'(r);
  endtask

  function automatic logic [N*WIDTH-1:0] pack(input int v0, input int v1);
    logic [WIDTH-1:0] l0, l1;
    l0 = WIDTH'(v0);
    l1 = WIDTH'(v1);
    return {l1, l0};
  endfunction

  task automatic fill(input int j, input int a0, input int a1, input int b0, input int b1);
    ta[j][0] = a0; ta[j][1] = a1; tbv[j][0] = b0; tbv[j][1] = b1;
  endtask

  // stall < 0: random 0..2 idle cycles before each beat; otherwise fixed gap between beats.
  task automatic run_job(input string nm, input int len, input int bias, input int stall,
                         input bit poke, output int oy, output int osat);
    int eff, lat, ns, b0, a0, r0;
    eff = (len > MAXLEN) ? MAXLEN : len;
    b0 = beat_cnt; a0 = ack_cnt; r0 = rdy_cnt;
    bus.start = 1'b1;
    bus.len   = LENW'(len);
    bus.bias  = (2*WIDTH)'(bias);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({nm, "_ack"}, bus.ack, 1);
    check({nm, "_rdy"}, bus.in_ready, (eff != 0) ? 1 : 0);
    for (int j = 0; j < eff; j++) begin
      ns = (stall < 0) ? int'($urandom_range(0, 2)) : ((j == 0) ? 0 : stall);
      repeat (ns) begin
        bus.in_valid = 1'b0;
        bus.a = (N*WIDTH)'($urandom);
        bus.b = (N*WIDTH)'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.a = pack(ta[j][0], ta[j][1]);
      bus.b = pack(tbv[j][0], tbv[j][1]);
      if (poke && j == 0) begin
        bus.start = 1'b1;
        bus.len   = '0;
      end
      lat = 0;
      while (!bus.in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.a = (N*WIDTH)'($urandom);
    bus.b = (N*WIDTH)'($urandom);
    lat = 0;
    while (!bus.done && lat < 20) begin @(posedge clk); #1; lat++; end
    check({nm, "_lat"}, lat, 2);
    oy   = int'($signed(bus.y));
    osat = int'(bus.sat);
    check({nm, "_beats"}, beat_cnt - b0, eff);
    check({nm, "_acks"}, ack_cnt - a0, 1);
    if (eff == 0) check({nm, "_rdy_never"}, rdy_cnt - r0, 0);
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int y, s, ey, es, bias, len;
    bus.start = 1'b0; bus.len = '0; bus.bias = '0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ack", bus.ack, 0);
    check("rst_done", bus.done, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_rdy", bus.in_ready, 0);
    check("rst_y", bus.y, 0);

    // 1: single beat, 2.0
    fill(0, 16, 16, 16, 16);
    run_job("t1", 1, 0, 0, 1'b0, y, s);
    check("t1_y", y, 64);
    check("t1_sat", s, 0);

    // 2: three beats with two idle cycles between them, 12.0
    for (int j = 0; j < 3; j++) fill(j, 32, 32, 16, 16);
    run_job("t2", 3, 0, 2, 1'b0, y, s);
    check("t2_y", y, 384);
    check("t2_sat", s, 0);

    // 3: full-scale beats clip the output, next small job clears sat
    for (int j = 0; j < 16; j++) fill(j, 127, 127, 127, 127);
    run_job("t3", 16, 0, 0, 1'b0, y, s);
    check("t3_y", y, 32767);
    check("t3_sat", s, 1);
    fill(0, 16, 16, 16, 16);
    run_job("t3b", 1, 0, 0, 1'b0, y, s);
    check("t3b_y", y, 64);
    check("t3b_sat", s, 0);

    // 4: empty job returns rounded bias
    run_job("t4", 0, 4, 0, 1'b0, y, s);
    check("t4_y", y, 1);
    check("t4_sat", s, 0);

    // 5: negative product, start poked mid-job
    fill(0, -16, -16, 16, 16);
    run_job("t5", 1, 0, 0, 1'b1, y, s);
    check("t5_y", y, -64);
    check("t5_sat", s, 0);

    // 6: reset after 2 of 5 beats
    bus.start = 1'b1; bus.len = LENW'(5); bus.bias = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = pack(16, 16); bus.b = pack(16, 16);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_y", bus.y, 0);
    check("t6_sat", bus.sat, 0);
    check("t6_done", bus.done, 0);
    check("t6_ack", bus.ack, 0);
    check("t6_rdy", bus.in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    fill(0, 16, 16, 16, 16);
    run_job("t6b", 1, 0, 0, 1'b0, y, s);
    check("t6b_y", y, 64);

    // len above MAXLEN is clamped
    for (int j = 0; j < MAXLEN; j++)
      fill(j, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    model(20, 100, ey, es);
    run_job("clamp", 20, 100, -1, 1'b0, y, s);
    check("clamp_y", y, ey);
    check("clamp_sat", s, es);

    // randomized jobs
    for (int k = 0; k < 10; k++) begin
      len  = int'($urandom_range(0, MAXLEN));
      bias = int'($urandom_range(0, 65535)) - 32768;
      for (int j = 0; j < MAXLEN; j++)
        fill(j, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      model(len, bias, ey, es);
      run_job($sformatf("rnd%0d", k), len, bias, -1, 1'b0, y, s);
      check($sformatf("rnd%0d_y", k), y, ey);
      check($sformatf("rnd%0d_sat", k), s, es);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
